// File: rtl/dpram_pkg.sv
// Shared definitions for the parametrised dual-port RAM and its clear sequencer.
package dpram_pkg;

    // Clear sequencer states: SWEEP fills the array, IDLE leaves it to the user ports.
    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } sweep_state_e;

    // When both ports write the same lane of the same word, port A's data lands.
    localparam bit PORT_A_WINS = 1'b1;

    // Number of byte lanes in a data word.
    function automatic int laneCount(input int dataW);
        return dataW / 8;
    endfunction

endpackage

// File: rtl/dpram_clear_seq.sv
// Clear sequencer: sweeps every address once after reset release or a CLEAR pulse.
// The sweep write is muxed onto port A by the top level.
module dpram_clear_seq
    import dpram_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    output logic              busy_o,
    output logic              sweepWe_o,
    output logic [ADDR_W-1:0] sweepAddr_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    sweep_state_e      state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;

    // Sweep FSM: CLEAR always restarts at address 0, the last address hands over to IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else if (clear_i) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                SWEEP: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign sweepWe_o   = busy_q;
    assign sweepAddr_o = cnt_q;

endmodule

// File: rtl/dpram_param_sc.sv
// Parametrised single-clock true dual-port RAM with byte enables, read valids,
// optional output register, hardware clear sweep and write-first bypass.
module dpram_param_sc
    import dpram_pkg::*;
#(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 8,
    parameter int                 OUT_REG  = 0,
    parameter logic [DATA_W-1:0]  INIT_VAL = 16'hFFFF
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  CLEAR,
    output logic                  BUSY,
    input  logic [DATA_W/8-1:0]   WEN_A,
    input  logic                  REN_A,
    input  logic [ADDR_W-1:0]     ADDR_A,
    input  logic [DATA_W-1:0]     DATA_IN_A,
    output logic [DATA_W-1:0]     DATA_OUT_A,
    output logic                  RVALID_A,
    input  logic [DATA_W/8-1:0]   WEN_B,
    input  logic                  REN_B,
    input  logic [ADDR_W-1:0]     ADDR_B,
    input  logic [DATA_W-1:0]     DATA_IN_B,
    output logic [DATA_W-1:0]     DATA_OUT_B,
    output logic                  RVALID_B,
    output logic                  COLLISION
);

    localparam int LANES = laneCount(DATA_W);
    localparam int DEPTH = 1 << ADDR_W;

    logic              busy;
    logic              sweepWe;
    logic [ADDR_W-1:0] sweepAddr;

    logic [LANES-1:0]  userWeA, userWeB;
    logic              renA, renB;
    logic [LANES-1:0]  weA;
    logic [ADDR_W-1:0] addrA;
    logic [DATA_W-1:0] dinA;

    logic [LANES-1:0]  hiWe, loWe;
    logic [ADDR_W-1:0] hiAddr, loAddr;
    logic [DATA_W-1:0] hiDin, loDin;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] rdWordA, rdWordB;
    logic [DATA_W-1:0] rdataA_q, rdataA_d, rdataB_q, rdataB_d;
    logic              rvalidA_q, rvalidB_q;
    logic              collision_q;

    dpram_clear_seq #(
        .ADDR_W(ADDR_W)
    ) uClearSeq (
        .clk_i      (CLK),
        .rst_ni     (RESETN),
        .clear_i    (CLEAR),
        .busy_o     (busy),
        .sweepWe_o  (sweepWe),
        .sweepAddr_o(sweepAddr)
    );

    assign BUSY = busy;

    // User strobes are discarded outright while the sweep owns the array.
    assign userWeA = busy ? '0 : WEN_A;
    assign userWeB = busy ? '0 : WEN_B;
    assign renA    = REN_A & ~busy;
    assign renB    = REN_B & ~busy;

    // The sweep borrows port A's write path.
    assign weA   = sweepWe ? '1        : userWeA;
    assign addrA = sweepWe ? sweepAddr : ADDR_A;
    assign dinA  = sweepWe ? INIT_VAL  : DATA_IN_A;

    assign hiWe   = PORT_A_WINS ? weA       : userWeB;
    assign hiAddr = PORT_A_WINS ? addrA     : ADDR_B;
    assign hiDin  = PORT_A_WINS ? dinA      : DATA_IN_B;
    assign loWe   = PORT_A_WINS ? userWeB   : weA;
    assign loAddr = PORT_A_WINS ? ADDR_B    : addrA;
    assign loDin  = PORT_A_WINS ? DATA_IN_B : dinA;

    // Word as it will look after this edge: stored value overlaid with lower-then-higher priority writes.
    function automatic logic [DATA_W-1:0] mergeLanes(
        input logic [DATA_W-1:0] base,
        input logic [ADDR_W-1:0] rdAddr,
        input logic [LANES-1:0]  lWe,
        input logic [ADDR_W-1:0] lAddr,
        input logic [DATA_W-1:0] lDin,
        input logic [LANES-1:0]  hWe,
        input logic [ADDR_W-1:0] hAddr,
        input logic [DATA_W-1:0] hDin
    );
        logic [DATA_W-1:0] word;
        word = base;
        for (int k = 0; k < LANES; k++) begin
            if (lWe[k] && (lAddr == rdAddr)) word[k*8 +: 8] = lDin[k*8 +: 8];
            if (hWe[k] && (hAddr == rdAddr)) word[k*8 +: 8] = hDin[k*8 +: 8];
        end
        return word;
    endfunction

    // Byte-lane writes; the higher-priority port is assigned last so it wins shared lanes.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < LANES; k++) begin
            if (loWe[k]) mem[loAddr][k*8 +: 8] <= loDin[k*8 +: 8];
            if (hiWe[k]) mem[hiAddr][k*8 +: 8] <= hiDin[k*8 +: 8];
        end
    end

    // Write-first read words for both ports, including cross-port bypass.
    always_comb begin
        rdWordA = mergeLanes(mem[ADDR_A], ADDR_A, loWe, loAddr, loDin, hiWe, hiAddr, hiDin);
        rdWordB = mergeLanes(mem[ADDR_B], ADDR_B, loWe, loAddr, loDin, hiWe, hiAddr, hiDin);
    end

    // Read data registers only update on an accepted read so the outputs hold otherwise.
    always_comb begin
        rdataA_d = rdataA_q;
        rdataB_d = rdataB_q;
        if (renA) rdataA_d = rdWordA;
        if (renB) rdataB_d = rdWordB;
    end

    // First read stage: data plus one-cycle valid per port.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            rdataA_q  <= '0;
            rdataB_q  <= '0;
            rvalidA_q <= 1'b0;
            rvalidB_q <= 1'b0;
        end else begin
            rdataA_q  <= rdataA_d;
            rdataB_q  <= rdataB_d;
            rvalidA_q <= renA;
            rvalidB_q <= renB;
        end
    end

    generate
        if (OUT_REG != 0) begin : gOutReg
            logic [DATA_W-1:0] outA_q, outB_q;
            logic              outValidA_q, outValidB_q;

            // Optional second stage: retimes data and valid by one more cycle.
            always_ff @(posedge CLK or negedge RESETN) begin
                if (!RESETN) begin
                    outA_q      <= '0;
                    outB_q      <= '0;
                    outValidA_q <= 1'b0;
                    outValidB_q <= 1'b0;
                end else begin
                    outValidA_q <= rvalidA_q;
                    outValidB_q <= rvalidB_q;
                    if (rvalidA_q) outA_q <= rdataA_q;
                    if (rvalidB_q) outB_q <= rdataB_q;
                end
            end

            assign DATA_OUT_A = outA_q;
            assign DATA_OUT_B = outB_q;
            assign RVALID_A   = outValidA_q;
            assign RVALID_B   = outValidB_q;
        end else begin : gNoOutReg
            assign DATA_OUT_A = rdataA_q;
            assign DATA_OUT_B = rdataB_q;
            assign RVALID_A   = rvalidA_q;
            assign RVALID_B   = rvalidB_q;
        end
    endgenerate

    // Sticky flag for both user ports writing one address in the same cycle; CLEAR drops it.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            collision_q <= 1'b0;
        end else if (CLEAR) begin
            collision_q <= 1'b0;
        end else if ((|userWeA) && (|userWeB) && (ADDR_A == ADDR_B)) begin
            collision_q <= 1'b1;
        end
    end

    assign COLLISION = collision_q;

endmodule

// File: tb/tb_dpram_param_sc.sv
// Scoreboard bench for dpram_param_sc: one instance with OUT_REG=0, one with OUT_REG=1.
module tb_dpram_param_sc;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        clear0 = 1'b0;
    logic        clear1 = 1'b0;

    logic [1:0]  wenA0 = '0, wenB0 = '0, wenA1 = '0, wenB1 = '0;
    logic        renA0 = 1'b0, renB0 = 1'b0, renA1 = 1'b0, renB1 = 1'b0;
    logic [7:0]  addrA0 = '0, addrB0 = '0, addrA1 = '0, addrB1 = '0;
    logic [15:0] dinA0 = '0, dinB0 = '0, dinA1 = '0, dinB1 = '0;

    logic        busy0, busy1, coll0, coll1;
    logic        rvA0, rvB0, rvA1, rvB1;
    logic [15:0] doutA0, doutB0, doutA1, doutB1;

    int          cyc = 0;
    int          assertCount = 0;
    int          failCount = 0;
    exp_t        expQ[4][$];
    string       portName[4] = '{"dut0 A", "dut0 B", "dut1 A", "dut1 B"};
    logic [15:0] vals[4] = '{16'hC000, 16'hC111, 16'hC222, 16'hC333};

    dpram_param_sc #(.DATA_W(16), .ADDR_W(8), .OUT_REG(0), .INIT_VAL(16'hFFFF)) dut0 (
        .CLK(CLK), .RESETN(RESETN), .CLEAR(clear0), .BUSY(busy0),
        .WEN_A(wenA0), .REN_A(renA0), .ADDR_A(addrA0), .DATA_IN_A(dinA0),
        .DATA_OUT_A(doutA0), .RVALID_A(rvA0),
        .WEN_B(wenB0), .REN_B(renB0), .ADDR_B(addrB0), .DATA_IN_B(dinB0),
        .DATA_OUT_B(doutB0), .RVALID_B(rvB0),
        .COLLISION(coll0)
    );

    dpram_param_sc #(.DATA_W(16), .ADDR_W(8), .OUT_REG(1), .INIT_VAL(16'hFFFF)) dut1 (
        .CLK(CLK), .RESETN(RESETN), .CLEAR(clear1), .BUSY(busy1),
        .WEN_A(wenA1), .REN_A(renA1), .ADDR_A(addrA1), .DATA_IN_A(dinA1),
        .DATA_OUT_A(doutA1), .RVALID_A(rvA1),
        .WEN_B(wenB1), .REN_B(renB1), .ADDR_B(addrB1), .DATA_IN_B(dinB1),
        .DATA_OUT_B(doutB1), .RVALID_B(rvB1),
        .COLLISION(coll1)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 CLK = ~CLK;

    // Cycle counter used to timestamp expected read responses.
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic monitorPort(input int idx, input logic valid, input logic [15:0] data);
        exp_t e;
        if (valid) begin
            assertCount++;
            if (expQ[idx].size() == 0) begin
                failCount++;
                $display("[TB] FAIL %s unexpected rvalid: got data %h at cycle %0d, expected no response", portName[idx], data, cyc);
            end else begin
                e = expQ[idx].pop_front();
                if (e.due != cyc || e.data !== data) begin
                    failCount++;
                    $display("[TB] FAIL %s read: got %h at cycle %0d, expected %h at cycle %0d", portName[idx], data, cyc, e.data, e.due);
                end
            end
        end else if (expQ[idx].size() > 0 && expQ[idx][0].due <= cyc) begin
            e = expQ[idx].pop_front();
            assertCount++;
            failCount++;
            $display("[TB] FAIL %s missing rvalid: got none at cycle %0d, expected %h at cycle %0d", portName[idx], cyc, e.data, e.due);
        end
    endtask

    // Monitor: pops the scoreboard whenever a port presents (or should present) read data.
    always @(negedge CLK) begin
        monitorPort(0, rvA0, doutA0);
        monitorPort(1, rvB0, doutB0);
        monitorPort(2, rvA1, doutA1);
        monitorPort(3, rvB1, doutB1);
    end

    // Drives one cycle on the selected instance and records the expected read responses.
    task automatic applyStimulus(
        input int dutSel,
        input logic [1:0] wA, input logic rA, input logic [7:0] aA, input logic [15:0] dA, input logic [15:0] eA,
        input logic [1:0] wB, input logic rB, input logic [7:0] aB, input logic [15:0] dB, input logic [15:0] eB,
        input bit pushExp
    );
        int lat;
        exp_t e;
        lat = (dutSel == 0) ? 1 : 2;
        if (dutSel == 0) begin
            wenA0 = wA; renA0 = rA; addrA0 = aA; dinA0 = dA;
            wenB0 = wB; renB0 = rB; addrB0 = aB; dinB0 = dB;
        end else begin
            wenA1 = wA; renA1 = rA; addrA1 = aA; dinA1 = dA;
            wenB1 = wB; renB1 = rB; addrB1 = aB; dinB1 = dB;
        end
        if (pushExp && rA) begin
            e.data = eA; e.due = cyc + lat;
            expQ[dutSel * 2].push_back(e);
        end
        if (pushExp && rB) begin
            e.data = eB; e.due = cyc + lat;
            expQ[dutSel * 2 + 1].push_back(e);
        end
        @(negedge CLK);
        wenA0 = '0; renA0 = 1'b0; wenB0 = '0; renB0 = 1'b0;
        wenA1 = '0; renA1 = 1'b0; wenB1 = '0; renB1 = 1'b0;
    endtask

    task automatic pulseClear();
        clear0 = 1'b1;
        @(negedge CLK);
        clear0 = 1'b0;
    endtask

    task automatic countBusy(output int n);
        n = 0;
        while (busy0 && n < 400) begin
            n++;
            @(negedge CLK);
        end
    endtask

    // Watchdog: guarantees termination if something stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before time 1000000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        int n;
        repeat (3) @(negedge CLK);
        $display("[TB] reset state");
        checkOutput("reset DATA_OUT_A", {16'h0, doutA0}, 32'h0);
        checkOutput("reset DATA_OUT_B", {16'h0, doutB0}, 32'h0);
        checkOutput("reset RVALID_A", {31'h0, rvA0}, 32'h0);
        checkOutput("reset RVALID_B", {31'h0, rvB0}, 32'h0);
        checkOutput("reset COLLISION", {31'h0, coll0}, 32'h0);
        checkOutput("reset BUSY", {31'h0, busy0}, 32'h1);

        RESETN = 1'b1;
        countBusy(n);
        checkOutput("busy cycles after reset", n, 256);

        $display("[TB] full array read after sweep");
        for (int i = 0; i < 256; i++) begin
            applyStimulus(0, 2'b00, 1'b1, 8'(i), 16'h0, 16'hFFFF,
                             2'b00, 1'b1, 8'(255 - i), 16'h0, 16'hFFFF, 1'b1);
        end

        $display("[TB] byte-lane writes and write-first reads");
        applyStimulus(0, 2'b11, 1'b0, 8'h10, 16'h1234, 16'h0, 2'b00, 1'b0, 8'h00, 16'h0, 16'h0, 1'b1);
        applyStimulus(0, 2'b01, 1'b1, 8'h10, 16'hAB56, 16'h1256, 2'b00, 1'b1, 8'h10, 16'h0, 16'h1256, 1'b1);
        applyStimulus(0, 2'b00, 1'b1, 8'h10, 16'h0, 16'h1256, 2'b00, 1'b0, 8'h00, 16'h0, 16'h0, 1'b1);
        applyStimulus(0, 2'b00, 1'b0, 8'h00, 16'h0, 16'h0, 2'b00, 1'b0, 8'h00, 16'h0, 16'h0, 1'b1);
        checkOutput("hold RVALID_A", {31'h0, rvA0}, 32'h0);
        checkOutput("hold DATA_OUT_A", {16'h0, doutA0}, 32'h1256);
        checkOutput("no collision yet", {31'h0, coll0}, 32'h0);

        $display("[TB] same-address writes from both ports");
        applyStimulus(0, 2'b11, 1'b0, 8'h20, 16'hAAAA, 16'h0, 2'b10, 1'b0, 8'h20, 16'h5555, 16'h0, 1'b1);
        checkOutput("COLLISION set", {31'h0, coll0}, 32'h1);
        applyStimulus(0, 2'b01, 1'b0, 8'h21, 16'h00CC, 16'h0, 2'b10, 1'b0, 8'h21, 16'h7700, 16'h0, 1'b1);
        applyStimulus(0, 2'b00, 1'b1, 8'h20, 16'h0, 16'hAAAA, 2'b00, 1'b1, 8'h21, 16'h0, 16'h77CC, 1'b1);

        $display("[TB] cross-port bypass");
        applyStimulus(0, 2'b11, 1'b0, 8'h30, 16'hBEEF, 16'h0, 2'b00, 1'b1, 8'h30, 16'h0, 16'hBEEF, 1'b1);
        applyStimulus(0, 2'b00, 1'b1, 8'h30, 16'h0, 16'hBEEF, 2'b00, 1'b0, 8'h00, 16'h0, 16'h0, 1'b1);
        checkOutput("COLLISION sticky", {31'h0, coll0}, 32'h1);

        pulseClear();
        checkOutput("COLLISION after CLEAR", {31'h0, coll0}, 32'h0);
        checkOutput("BUSY after CLEAR", {31'h0, busy0}, 32'h1);
        countBusy(n);
        checkOutput("busy cycles after CLEAR", n, 256);
        applyStimulus(0, 2'b00, 1'b1, 8'h20, 16'h0, 16'hFFFF, 2'b00, 1'b1, 8'h30, 16'h0, 16'hFFFF, 1'b1);

        $display("[TB] CLEAR restart mid-sweep");
        pulseClear();
        repeat (100) @(negedge CLK);
        pulseClear();
        countBusy(n);
        checkOutput("busy cycles after restart", n, 256);

        $display("[TB] reset abort mid-sweep");
        pulseClear();
        repeat (50) @(negedge CLK);
        applyStimulus(0, 2'b11, 1'b1, 8'h05, 16'h1111, 16'h0, 2'b00, 1'b1, 8'h06, 16'h0, 16'h0, 1'b0);
        RESETN = 1'b0;
        #1;
        checkOutput("mid-sweep reset BUSY", {31'h0, busy0}, 32'h1);
        checkOutput("mid-sweep reset DATA_OUT_A", {16'h0, doutA0}, 32'h0);
        checkOutput("mid-sweep reset RVALID_A", {31'h0, rvA0}, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RESETN = 1'b1;
        n = 0;
        while (busy0 && n < 400) begin
            n++;
            applyStimulus(0, (n == 60) ? 2'b11 : 2'b00, 1'b1, 8'h05, 16'h2222, 16'h0,
                             2'b00, 1'b1, 8'h80, 16'h0, 16'h0, 1'b0);
            checkOutput("RVALID_A while busy", {31'h0, rvA0}, 32'h0);
            checkOutput("RVALID_B while busy", {31'h0, rvB0}, 32'h0);
        end
        checkOutput("busy cycles after reset abort", n, 256);
        applyStimulus(0, 2'b00, 1'b1, 8'h05, 16'h0, 16'hFFFF, 2'b00, 1'b1, 8'h30, 16'h0, 16'hFFFF, 1'b1);

        $display("[TB] output register back-to-back reads");
        checkOutput("dut1 BUSY idle", {31'h0, busy1}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 2'b11, 1'b0, 8'(i), vals[i], 16'h0, 2'b00, 1'b0, 8'h00, 16'h0, 16'h0, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 2'b00, 1'b1, 8'(i), 16'h0, vals[i],
                             2'b00, 1'b1, 8'(3 - i), 16'h0, vals[3 - i], 1'b1);
        end

        repeat (4) @(negedge CLK);
        for (int q = 0; q < 4; q++) begin
            checkOutput({portName[q], " pending responses"}, expQ[q].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
